// File: rtl/riscv_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : riscv_pkg                                                       |
// | Brief    : Shared core types plus fetch-queue entry type and helpers.      |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package riscv_pkg;

  localparam int XLEN            = 32;
  localparam int IMEM_WORD_BYTES = 4;

  typedef logic [XLEN-1:0] xlen_t;

  typedef struct packed {
    xlen_t       pc;
    logic [31:0] instr;
  } if_id_t;

  typedef struct packed {
    xlen_t       pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fetch_fifo                                                      |
// | Brief    : Synchronous FIFO of type T with flush, full/empty and count.    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module fetch_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic [31:0],
  parameter int  CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_flush,
  input  logic             i_push,
  input  T                 i_push_data,
  input  logic             i_pop,
  output T                 o_pop_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count
);

  localparam int               c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [c_ptr_w-1:0] c_last  = c_ptr_w'(DEPTH - 1);
  localparam logic [CNT_W-1:0]   c_depth = CNT_W'(DEPTH);

  T                   r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               w_do_push;
  logic               w_do_pop;

  assign o_empty    = (r_count == '0);
  assign o_full     = (r_count == c_depth);
  assign o_count    = r_count;
  assign o_pop_data = r_mem[r_rd_ptr];

  // A full FIFO may still accept a push when the head leaves in the same cycle.
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= (r_wr_ptr == c_last) ? '0 : r_wr_ptr + c_ptr_w'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= (r_rd_ptr == c_last) ? '0 : r_rd_ptr + c_ptr_w'(1);
      end
      r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
    end
  end

endmodule
`default_nettype wire

// File: rtl/if_prefetch_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : if_prefetch_stage                                               |
// | Brief    : Fetch stage with prefetch queue; optional perf counters under   |
// |            IF_PERF_CNT_EN.                                                 |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module if_prefetch_stage
  import riscv_pkg::*;
#(
  parameter xlen_t RESET_PC        = 32'h0000_0000,
  parameter int    DEPTH           = 4,
  parameter int    MAX_OUTSTANDING = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       redirect_valid,
  input  logic [XLEN-1:0]            redirect_pc,
  output logic                       imem_req,
  output logic [XLEN-1:0]            imem_addr,
  input  logic                       imem_gnt,
  input  logic                       imem_rvalid,
  input  logic [31:0]                imem_rdata,
  output logic                       id_valid,
  input  logic                       id_ready,
  output logic [$bits(if_id_t)-1:0]  id_data
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]                perf_fetch_cnt,
  output logic [31:0]                perf_drop_cnt
`endif
);

  localparam int                 c_inf_w   = $clog2(MAX_OUTSTANDING + 1);
  localparam int                 c_cnt_w   = $clog2(DEPTH + 1);
  localparam logic [c_inf_w-1:0] c_max_out = c_inf_w'(MAX_OUTSTANDING);

  xlen_t              r_pc;
  logic [c_inf_w-1:0] r_inflight;
  logic [c_inf_w-1:0] r_discard;

  logic [c_inf_w-1:0] w_live;
  logic [31:0]        w_used;
  logic               w_grant;
  logic               w_rsp;
  logic               w_keep;
  logic               w_drop;
  logic               w_pop;
  xlen_t              w_redirect_pc;
  fetch_entry_t       w_push_entry;
  fetch_entry_t       w_head;
  logic               w_fifo_full;
  logic               w_fifo_empty;
  logic [c_cnt_w-1:0] w_fifo_count;
  xlen_t              w_pcq_head;
  logic               w_pcq_full;
  logic               w_pcq_empty;
  logic [c_inf_w-1:0] w_pcq_count;
  logic               w_unused;

  assign w_unused      = ^{redirect_pc[1:0], r_pc[1:0]};
  assign w_redirect_pc = {redirect_pc[XLEN-1:2], 2'b00};
  assign imem_addr     = {r_pc[XLEN-1:2], 2'b00};

  // Requests still owed to the FIFO each reserve a slot, so a push never overflows.
  assign w_live   = r_inflight - r_discard;
  assign w_used   = 32'(w_live) + 32'(w_fifo_count);
  assign imem_req = rst_n && !redirect_valid && (r_inflight < c_max_out) && (w_used < 32'(DEPTH));

  assign w_grant = imem_req && imem_gnt;
  assign w_rsp   = imem_rvalid && (r_inflight != '0);
  assign w_keep  = w_rsp && (r_discard == '0) && !redirect_valid;
  assign w_drop  = w_rsp && !w_keep;

  assign id_valid = !w_fifo_empty && !redirect_valid;
  assign w_pop    = id_valid && id_ready;
  assign id_data  = w_head;

  assign w_push_entry = {w_pcq_head, imem_rdata};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc       <= RESET_PC;
      r_inflight <= '0;
      r_discard  <= '0;
    end else if (redirect_valid) begin
      // Every request still in flight belongs to the abandoned path.
      r_pc       <= w_redirect_pc;
      r_inflight <= r_inflight - c_inf_w'(w_rsp);
      r_discard  <= r_inflight - c_inf_w'(w_rsp);
    end else begin
      if (w_grant) begin
        r_pc <= r_pc + xlen_t'(IMEM_WORD_BYTES);
      end
      r_inflight <= r_inflight + c_inf_w'(w_grant) - c_inf_w'(w_rsp);
      if (w_drop) begin
        r_discard <= r_discard - c_inf_w'(1);
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .T     (fetch_entry_t)
  ) u_entry_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_flush     (redirect_valid),
    .i_push      (w_keep),
    .i_push_data (w_push_entry),
    .i_pop       (w_pop),
    .o_pop_data  (w_head),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty),
    .o_count     (w_fifo_count)
  );

  // Addresses of live requests only; discarded responses never consume a tag.
  fetch_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .T     (xlen_t)
  ) u_pc_queue (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_flush     (redirect_valid),
    .i_push      (w_grant),
    .i_push_data (imem_addr),
    .i_pop       (w_keep),
    .o_pop_data  (w_pcq_head),
    .o_full      (w_pcq_full),
    .o_empty     (w_pcq_empty),
    .o_count     (w_pcq_count)
  );

`ifdef IF_PERF_CNT_EN
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_drop_cnt;
  logic [31:0] w_drop_inc;

  assign w_drop_inc = (redirect_valid ? 32'(w_fifo_count) : 32'd0) + 32'(w_drop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_cnt <= '0;
      r_drop_cnt  <= '0;
    end else begin
      r_fetch_cnt <= sat_add32(r_fetch_cnt, 32'(w_pop));
      r_drop_cnt  <= sat_add32(r_drop_cnt, w_drop_inc);
    end
  end

  assign perf_fetch_cnt = r_fetch_cnt;
  assign perf_drop_cnt  = r_drop_cnt;
`endif

  a_rvalid_without_request: assert property (@(posedge clk) disable iff (!rst_n)
    !(imem_rvalid && (r_inflight == '0)));
  a_pcq_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(w_grant && w_pcq_full));
  a_pcq_tag_present: assert property (@(posedge clk) disable iff (!rst_n)
    !(w_keep && w_pcq_empty));
  a_pcq_tracks_live: assert property (@(posedge clk) disable iff (!rst_n)
    w_pcq_count == w_live);
  a_fifo_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(w_keep && w_fifo_full && !w_pop));

endmodule
`default_nettype wire

// File: tb/tb_if_prefetch_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_if_prefetch_stage                                            |
// | Brief    : Self-checking bench for if_prefetch_stage (memory model and     |
// |            in-order PC stream reference).                                  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_if_prefetch_stage;

  localparam int DEPTH   = 4;
  localparam int MAX_OUT = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [63:0] id_data;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_drop_cnt;
`endif

  always #5 clk = ~clk;

  if_prefetch_stage #(
    .RESET_PC        (32'h0000_0000),
    .DEPTH           (DEPTH),
    .MAX_OUTSTANDING (MAX_OUT)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_data        (id_data)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_drop_cnt  (perf_drop_cnt)
`endif
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
    int          epoch;
  } req_t;

  req_t        pend[$];
  logic [31:0] popped[$];
  int          cyc, epoch, live, buffered;
  int          n_grants, n_pops, lat_lo, lat_hi;
  int          n_total, n_pass, n_fail;
  longint      drops;
  logic [31:0] exp_pc, exp_addr;
  logic        last_req, last_valid;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:2], 2'b11, ~a[17:2]} ^ 32'h5A3C_0F96;
  endfunction

  function automatic logic [31:0] popped_at(input int i);
    return (popped.size() > i) ? popped[i] : 32'hBAD0_BAD0;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst_n = 1'b0;
    redirect_valid = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; id_ready = 1'b0;
    pend.delete(); popped.delete();
    epoch = 0; live = 0; buffered = 0; drops = 0; n_pops = 0; n_grants = 0;
    exp_pc = '0; exp_addr = '0;
    #1;
    check("rst_req", 64'(imem_req), 64'd0);
    check("rst_valid", 64'(id_valid), 64'd0);
    check("rst_data", id_data, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock: drive at the falling edge, observe 1 ns later, then advance the model.
  task automatic cycle(input logic redir, input logic [31:0] rpc, input logic gnt, input logic rdy);
    logic rsp, grant, pop;
    req_t nr, r;
    @(negedge clk);
    rsp = (pend.size() > 0) && (pend[0].due <= cyc);
    redirect_valid = redir; redirect_pc = rpc; imem_gnt = gnt; id_ready = rdy;
    imem_rvalid = rsp;
    imem_rdata = rsp ? mem_word(pend[0].addr) : 32'h0;
    #1;
    last_req = imem_req; last_valid = id_valid;
    grant = imem_req && gnt;
    pop = id_valid && rdy;
    if (redir) begin
      check("redir_req", 64'(imem_req), 64'd0);
      check("redir_valid", 64'(id_valid), 64'd0);
    end
    if (grant) begin
      check("grant_addr", 64'(imem_addr), 64'(exp_addr));
      check("grant_credit", 64'((pend.size() < MAX_OUT) && (live + buffered < DEPTH)), 64'd1);
      nr.addr = imem_addr;
      nr.due = cyc + int'($urandom_range(lat_hi, lat_lo));
      nr.epoch = epoch;
      exp_addr += 32'd4;
      n_grants++;
    end
    if (pop) begin
      check("id_pc", 64'(id_data[63:32]), 64'(exp_pc));
      check("id_instr", 64'(id_data[31:0]), 64'(mem_word(id_data[63:32])));
      popped.push_back(id_data[63:32]);
      exp_pc += 32'd4;
      buffered--;
      n_pops++;
    end
    if (rsp) begin
      r = pend.pop_front();
      if (redir || r.epoch != epoch) drops++;
      else begin
        live--;
        buffered++;
      end
    end
    if (grant) begin
      pend.push_back(nr);
      live++;
    end
    if (redir) begin
      drops += buffered;
      buffered = 0; live = 0; epoch++;
      exp_pc = {rpc[31:2], 2'b00};
      exp_addr = {rpc[31:2], 2'b00};
    end
    cyc++;
  endtask

  task automatic wait_first_pop(input int budget);
    for (int k = 0; k < budget && popped.size() == 0; k++) cycle(1'b0, 32'h0, 1'b1, 1'b1);
  endtask

  initial begin
    cyc = 0; n_total = 0; n_pass = 0; n_fail = 0;
    lat_lo = 1; lat_hi = 1;

    // Back-to-back streaming with 1-cycle memory.
    reset_dut();
    for (int i = 0; i < 12; i++) begin
      cycle(1'b0, 32'h0, 1'b1, 1'b1);
      check("t1_valid", 64'(last_valid), 64'(i >= 2));
    end

    // Decode stalled: queue fills to DEPTH, then requests stop.
    reset_dut();
    for (int i = 0; i < 10; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);
    check("t2_grants", 64'(n_grants), 64'(DEPTH));
    check("t2_req_stall", 64'(last_req), 64'd0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 32'h0, 1'b1, 1'b1);
    check("t2_pops", 64'(n_pops), 64'd4);
    for (int i = 0; i < 4; i++) check("t2_drain_pc", 64'(popped_at(i)), 64'(32'(4 * i)));

    // Redirect with two requests outstanding at latency 3.
    reset_dut();
    lat_lo = 3; lat_hi = 3;
    for (int k = 0; k < 10 && pend.size() < 2; k++) cycle(1'b0, 32'h0, 1'b1, 1'b1);
    check("t3_inflight", 64'(pend.size()), 64'd2);
    cycle(1'b1, 32'h100, 1'b1, 1'b1);
    popped.delete();
    wait_first_pop(30);
    check("t3_first_pc", 64'(popped_at(0)), 64'h100);

    // Redirect coincident with a response and an offered grant.
    reset_dut();
    lat_lo = 2; lat_hi = 2;
    for (int k = 0; k < 10 && !(pend.size() > 0 && pend[0].due <= cyc); k++)
      cycle(1'b0, 32'h0, 1'b1, 1'b1);
    check("t4_rsp_due", 64'(pend.size()), 64'd2);
    cycle(1'b1, 32'h40, 1'b1, 1'b1);
    popped.delete();
    wait_first_pop(30);
    check("t4_first_pc", 64'(popped_at(0)), 64'h40);

    // Address wrap and unaligned redirect target.
    lat_lo = 1; lat_hi = 1;
    cycle(1'b1, 32'hFFFF_FFF8, 1'b1, 1'b1);
    popped.delete();
    for (int k = 0; k < 30 && popped.size() < 3; k++) cycle(1'b0, 32'h0, 1'b1, 1'b1);
    check("t5_pc0", 64'(popped_at(0)), 64'hFFFF_FFF8);
    check("t5_pc1", 64'(popped_at(1)), 64'hFFFF_FFFC);
    check("t5_pc2", 64'(popped_at(2)), 64'h0000_0000);
    cycle(1'b1, 32'h203, 1'b1, 1'b1);
    popped.delete();
    wait_first_pop(30);
    check("t5_redirect_align", 64'(popped_at(0)), 64'h200);

    // Random traffic: variable latency, grant and ready jitter, sporadic redirects.
    reset_dut();
    lat_lo = 1; lat_hi = 4;
    for (int i = 0; i < 800; i++) begin
      cycle(($urandom_range(99) < 4) ? 1'b1 : 1'b0, $urandom,
            ($urandom_range(99) < 70) ? 1'b1 : 1'b0,
            ($urandom_range(99) < 60) ? 1'b1 : 1'b0);
    end
    check("rand_progress", 64'(n_pops > 50), 64'd1);
`ifdef IF_PERF_CNT_EN
    @(negedge clk);
    #1;
    check("perf_fetch", 64'(perf_fetch_cnt), 64'(n_pops));
    check("perf_drop", 64'(perf_drop_cnt), 64'(drops));
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
